// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-FSM state type, default frame geometry and a counter-width helper.
package uart_pkg;

  localparam int UART_DEF_M   = 8;
  localparam int UART_DEF_OVS = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// bit_sync2: two-flop synchronizer for an idle-high asynchronous line; both stages reset to 1.
module bit_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: FSM-sequenced UART frame receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit check and the parity_err pulse output.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int M   = UART_DEF_M,
  parameter int OVS = UART_DEF_OVS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  output logic [M-1:0] byte_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         frame_err,
  output logic         overrun,
`ifdef UART_RX_PARITY_EN
  output logic         parity_err,
`endif
  output logic         busy
);

  localparam int CW = cnt_width(OVS);
  localparam int IW = cnt_width(M);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);

  logic            rx_s;
  logic            discard;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [M-1:0]    shift_q, shift_d;
  logic [M-1:0]    byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic            perr_q, perr_d;
  logic            pbad_q, pbad_d;

  assign discard = pbad_q;
`else
  assign discard = 1'b0;
`endif

  bit_sync2 u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (bit_in),
    .q     (rx_s)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = valid_q && !ready_in;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif

    case (state_q)
      IDLE: if (!rx_s) state_d = START;
      START: if (cnt_q == CNT_MID) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        shift_d = (shift_q >> 1) | (M'(rx_s) << (M - 1));
        idx_d   = idx_q + IW'(1);
`ifdef UART_RX_PARITY_EN
        if (idx_q == IDX_LAST) state_d = PARITY;
`else
        if (idx_q == IDX_LAST) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = STOP;
        if (^{shift_q, rx_s}) begin
          perr_d = 1'b1;
          pbad_d = 1'b1;
        end
      end
`endif
      STOP: if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        pbad_d = 1'b0;
`endif
        if (rx_s) begin
          state_d = IDLE;
          // A full register is only overwritten when it is being consumed this very cycle.
          if (!discard) begin
            if (valid_q && !ready_in) begin
              ovr_d = 1'b1;
            end else begin
              byte_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  assign byte_out  = byte_q;
  assign valid_out = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
